// File: rtl/ctrl_encoder_loader.sv
// ctrl_encoder_loader: encodes control-intent vectors plus operand fields into
// 16-bit instruction words and streams them into instruction memory.
// Optional feature macro: CHECKSUM_EN (running XOR of every word written).
module ctrl_encoder_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_ctrl,
    input  logic [2:0]        in_ra,
    input  logic [2:0]        in_rb,
    input  logic [6:0]        in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count,
    output logic [15:0]       checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [6:0] imm;
    } instr_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [2:0] op;
    logic       legal;
    logic       is_halt;
    instr_t     word;

    // Opcode encoder: only the exact control vectors below are legal
    always_comb begin
        op      = 3'b000;
        legal   = 1'b1;
        is_halt = 1'b0;
        case (in_ctrl)
            7'b0100000: op = 3'b000;   // store
            7'b1010000: op = 3'b001;   // load
            7'b1001000: op = 3'b010;   // add
            7'b0000110: op = 3'b101;   // beq
            7'b0000001: begin          // halt
                op      = 3'b111;
                is_halt = 1'b1;
            end
            default:    legal = 1'b0;
        endcase
        word = '{op: op, ra: in_ra, rb: in_rb, imm: in_imm};
    end

    // Session FSM: next state, write-port register inputs and status flags
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    if (!legal) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = DATA_W'(word);
                        count_d = count_q + CNT_ONE;
                        // pointer saturates at the last slot; it never wraps
                        if (ptr_q != PTR_MAX) ptr_d = ptr_q + PTR_ONE;
                        if (is_halt) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (ptr_q == PTR_MAX) begin
                            state_d = ERROR;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                // IDLE, DONE and ERROR all (re)start a session the same way
                if (start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
        endcase
    end

    // State and output registers; reset drops any write registered this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = (state_q == LOAD);
    assign busy       = (state_q == LOAD);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign count      = count_q;

`ifdef CHECKSUM_EN
    logic        sess_clr;
    logic [15:0] csum_q, csum_d;

    // Running XOR of written words, updated alongside the wdata register
    always_comb begin
        sess_clr = start && (state_q != LOAD);
        csum_d   = csum_q;
        if (sess_clr)  csum_d = '0;
        else if (we_d) csum_d = csum_q ^ word;
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: doc/ctrl_encoder_loader.md
Name: ctrl_encoder_loader

Overview:
- Inverse of the processor's opcode decoder: takes control-intent vectors plus operand fields and encodes them into instruction words.
- Streams the encoded words sequentially into instruction memory through a write port.
- Sits between a program source (testbench or host stub) and the instruction memory; fills the program before the core runs.
- Terminates on a halt instruction; flags illegal control vectors and program overflow.

Parameters:
- ADDR_W, 5, instruction memory address width (depth = 2**ADDR_W).
- DATA_W, 16, instruction word width; fixed field layout requires 16.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin (or restart) a load session.
- in_valid  input  1  source presents an instruction.
- in_ready  output  1  loader can accept an instruction.
- in_ctrl  input  7  {regWrite, memWrite, memToReg, addition, aluF, branch, halt}.
- in_ra  input  3  register field A.
- in_rb  input  3  register field B.
- in_imm  input  7  immediate field.
- imem_we  output  1  one-cycle write strobe.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  DATA_W  encoded word.
- busy  output  1  state is LOAD.
- done  output  1  halt written successfully.
- err  output  1  illegal vector or overflow.
- count  output  ADDR_W+1  number of words written this session.
- checksum  output  16  see Optional Feature.

Behaviour:
- **Reset values:** state IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, count=0, checksum=0.
- **Encoding (exact match required):**
  - 0100000 -> op 000 (store).
  - 1010000 -> op 001 (load).
  - 1001000 -> op 010 (add).
  - 0000110 -> op 101 (beq).
  - 0000001 -> op 111 (halt).
  - Any other vector is illegal.
- **Word layout:** [15:13]=op, [12:10]=ra, [9:7]=rb, [6:0]=imm.
- **States:** IDLE, LOAD, DONE, ERROR.
- **IDLE:**
  - in_ready=0.
  - start -> LOAD; clears count, write pointer, done, err, checksum.
- **LOAD:**
  - in_ready=1 combinationally while in LOAD.
  - Handshake = in_valid & in_ready, sampled at the rising edge.
- **Legal accepted vector:**
  - At that edge, register imem_we=1, imem_addr=pointer, imem_wdata=encoded word.
  - Write is visible in the following cycle; one-cycle latency.
  - pointer++ and count++.
- **Legal halt accepted:** write performed as above; state -> DONE.
- **Illegal vector accepted:** no write; state -> ERROR; err=1.
- **Overflow:** a non-halt word accepted when pointer = 2**ADDR_W-1 is written, then state -> ERROR. Pointer does not wrap.
- **imem_we:** deasserts the cycle after any write. It is never high for two consecutive cycles without two handshakes.
- **DONE / ERROR:** in_ready=0; outputs held; start -> LOAD (restart as from IDLE).
- **start during LOAD:** ignored.
- **reset mid-session:**
  - All outputs return to reset values on the next edge.
  - A write registered in the same cycle is dropped (imem_we=0).
- **busy:** equals (state==LOAD).
- **done / err:** sticky until start or reset.

Optional Feature:
- Macro: CHECKSUM_EN.
- **Defined:** checksum = XOR of every word written this session. Updated at the same edge as the imem_wdata register; cleared on start and on reset.
- **Undefined:** checksum tied to 0; no extra logic.

Test Plan:
- reset; start; add (ctrl 1001000, ra=1, rb=2, imm=5); halt -> writes 0x4505@0 then 0xE000@1; done=1, count=2, in_ready=0; with CHECKSUM_EN, checksum=0xA505.
- start; load (1010000, ra=2, rb=0, imm=4), beq (0000110, ra=3, rb=3, imm=0x7F), store (0100000, all 0), halt -> words 0x2804, 0xADFF, 0x0000, 0xE000 at addresses 0-3, each one cycle after its handshake.
- start; legal add, then illegal ctrl 1111111 -> exactly one write (addr 0); err=1, done=0, count=1; start again -> count=0, err=0, LOAD.
- ADDR_W=2; start; four add vectors, no halt -> writes at addresses 0-3; after the 4th, err=1, count=4, in_ready=0, no 5th write.
- start; in_valid toggled with gaps; reset asserted on the cycle of a handshake -> no write next cycle; all outputs 0; state IDLE.
